// File: rtl/sine_ctrl_pkg.sv
// Shared FSM state type, direction encodings and default widths for the sine step controller.
package sine_ctrl_pkg;

    localparam int DEF_DIV_W   = 8;
    localparam int DEF_BURST_W = 8;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

endpackage

// File: rtl/sine_ctrl_if.sv
// Host/datapath bundle of the sine step controller; burst_cfg exists only with SINE_CTRL_BURST_EN.
interface sine_ctrl_if #(
    parameter int DIV_W = sine_ctrl_pkg::DEF_DIV_W
`ifdef SINE_CTRL_BURST_EN
    ,
    parameter int BURST_W = sine_ctrl_pkg::DEF_BURST_W
`endif
);

    logic             en;
    logic [DIV_W-1:0] div_cfg;
    logic             max;
    logic             zero;
`ifdef SINE_CTRL_BURST_EN
    logic [BURST_W-1:0] burst_cfg;
`endif
    logic             dir;
    logic             step_en;
    logic             polarity;
    logic             period_done;
    logic             busy;

`ifdef SINE_CTRL_BURST_EN
    modport master (
        output en, div_cfg, max, zero, burst_cfg,
        input  dir, step_en, polarity, period_done, busy
    );
    modport slave (
        input  en, div_cfg, max, zero, burst_cfg,
        output dir, step_en, polarity, period_done, busy
    );
`else
    modport master (
        output en, div_cfg, max, zero,
        input  dir, step_en, polarity, period_done, busy
    );
    modport slave (
        input  en, div_cfg, max, zero,
        output dir, step_en, polarity, period_done, busy
    );
`endif

endinterface

// File: rtl/sine_presc.sv
// Step-rate prescaler: loads a reload value, counts down, and emits a registered one-cycle pulse at zero.
module sine_presc
    import sine_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_reload,
    output logic             o_tc
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic             r_tc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
        end else if (i_load) begin
            r_cnt <= i_reload;
            r_tc  <= 1'b0;
        end else if (i_run) begin
            // Reload samples i_reload here, so a new divider only lands at the next terminal count.
            if (r_cnt == '0) begin
                r_cnt <= i_reload;
                r_tc  <= 1'b1;
            end else begin
                r_cnt <= r_cnt - ONE;
                r_tc  <= 1'b0;
            end
        end else begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
        end
    end

    assign o_tc = r_tc;

endmodule

// File: rtl/sine_ctrl.sv
// Sine step controller: paces the datapath counter, turns it at max/zero, and tracks lobe polarity.
// Optional burst limit (burst_cfg periods per run) is built when SINE_CTRL_BURST_EN is defined.
module sine_ctrl
    import sine_ctrl_pkg::*;
#(
    parameter int DIV_W   = DEF_DIV_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic       clk,
    input  logic       rst,
    sine_ctrl_if.slave bus
);

    state_t r_state;
    state_t w_state_next;
    logic   r_dir;
    logic   r_polarity;
    logic   r_period_done;
    logic   w_step;
    logic   w_load;
    logic   w_run;
    logic   w_max_turn;
    logic   w_zero_turn;
    logic   w_fault;
    logic   w_period_end;
    logic   w_burst_end;
    logic   w_blocked;

    sine_presc #(.DIV_W(DIV_W)) u_presc (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_run    (w_run),
        .i_reload (bus.div_cfg),
        .o_tc     (w_step)
    );

    // Flags only count on step cycles; both flags together mean the datapath is inconsistent.
    assign w_fault      = w_step && bus.max && bus.zero;
    assign w_max_turn   = w_step && (r_dir == DIR_UP)   && bus.max  && !bus.zero;
    assign w_zero_turn  = w_step && (r_dir == DIR_DOWN) && bus.zero && !bus.max;
    assign w_period_end = w_zero_turn && r_polarity;

`ifdef SINE_CTRL_BURST_EN
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    logic [BURST_W-1:0] r_burst_cnt;
    logic               r_blocked;

    assign w_burst_end = w_period_end && (bus.burst_cfg != '0)
                         && (r_burst_cnt == bus.burst_cfg - BURST_ONE);
    assign w_blocked   = r_blocked;

    // A finished burst keeps the FSM parked until en has been seen low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_burst_cnt <= '0;
            r_blocked   <= 1'b0;
        end else begin
            if (w_load) begin
                r_burst_cnt <= '0;
            end else if (w_period_end) begin
                r_burst_cnt <= r_burst_cnt + BURST_ONE;
            end
            if (w_burst_end) begin
                r_blocked <= 1'b1;
            end else if (!bus.en) begin
                r_blocked <= 1'b0;
            end
        end
    end
`else
    assign w_burst_end = 1'b0;
    assign w_blocked   = 1'b0;

    // BURST_W sizes nothing in this build; a zero width is left inert.
    if (BURST_W < 1) begin : g_burst_w_inert
    end
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.en && !w_blocked) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_fault || w_burst_end) begin
                    w_state_next = IDLE;
                end else if (!bus.en) begin
                    w_state_next = STOPPING;
                end
            end
            STOPPING: begin
                if (w_fault || w_burst_end) begin
                    w_state_next = IDLE;
                end else if (bus.en) begin
                    w_state_next = RUN;
                end else if (w_period_end) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        // Gating on the next state keeps step_en low from the very cycle the FSM lands in IDLE.
        w_load = (r_state == IDLE) && (w_state_next != IDLE);
        w_run  = (r_state != IDLE) && (w_state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_dir         <= DIR_UP;
            r_polarity    <= 1'b0;
            r_period_done <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_period_done <= w_period_end;
            if (w_max_turn) begin
                r_dir <= DIR_DOWN;
            end else if (w_zero_turn) begin
                r_dir      <= DIR_UP;
                r_polarity <= ~r_polarity;
            end
        end
    end

    assign bus.step_en     = w_step;
    assign bus.dir         = r_dir;
    assign bus.polarity    = r_polarity;
    assign bus.period_done = r_period_done;
    assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_sine_ctrl.sv
// Directed bench for sine_ctrl: per-cycle vector table plus hand sequences for divider timing,
// stop/restart, async reset, a 7-bit behavioural datapath, and (with SINE_CTRL_BURST_EN) bursts.
module tb_sine_ctrl;
    import sine_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sine_ctrl_if ifc ();

    sine_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    logic model_mode = 1'b0;
    logic tb_max  = 1'b0;
    logic tb_zero = 1'b0;
    logic [6:0] dp_cnt;

    // 7-bit datapath: max one below 127, zero one above 0; it shares rst with the controller.
    assign ifc.max  = model_mode ? (dp_cnt == 7'd126) : tb_max;
    assign ifc.zero = model_mode ? (dp_cnt == 7'd1)   : tb_zero;

    always @(posedge clk or negedge rst) begin
        if (!rst)              dp_cnt <= 7'd0;
        else if (ifc.step_en)  dp_cnt <= ifc.dir ? dp_cnt - 7'd1 : dp_cnt + 7'd1;
    end

    typedef struct {
        logic       en;
        logic [7:0] div;
        logic       mx;
        logic       zr;
        logic       step;
        logic       dir;
        logic       pol;
        logic       pd;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int en, int div, int mx, int zr,
                                int step, int dir, int pol, int pd, int busy);
        vec_t r;
        r.en   = (en != 0);
        r.div  = 8'(div);
        r.mx   = (mx != 0);
        r.zr   = (zr != 0);
        r.step = (step != 0);
        r.dir  = (dir != 0);
        r.pol  = (pol != 0);
        r.pd   = (pd != 0);
        r.busy = (busy != 0);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pd(input int bound, output int cycles);
        cycles = 0;
        while (ifc.period_done !== 1'b1 && cycles < bound) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int pd_seen;

        rst         = 1'b0;
        ifc.en      = 1'b0;
        ifc.div_cfg = 8'd0;
`ifdef SINE_CTRL_BURST_EN
        ifc.burst_cfg = 8'd0;
`endif
        #1;
        check("rst_step", ifc.step_en, 0);
        check("rst_dir", ifc.dir, 0);
        check("rst_pol", ifc.polarity, 0);
        check("rst_pd", ifc.period_done, 0);
        check("rst_busy", ifc.busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        //        en div mx zr | step dir pol pd busy  (outputs after the edge)
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0,  1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0,  1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1,  1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1,  1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0,  1, 1, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1,  1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 3, 0, 0,  1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 3, 1, 0,  0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 3, 0, 1,  0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 3, 1, 1,  0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 3, 0, 0,  1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 3, 0, 1,  0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0,  1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0,  1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 1, 1,  0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0,  1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0,  0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0,  1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1,  0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            ifc.en      = vecs[i].en;
            ifc.div_cfg = vecs[i].div;
            tb_max      = vecs[i].mx;
            tb_zero     = vecs[i].zr;
            tick();
            $display("vec %0d: en=%0b div=%0d max=%0b zero=%0b -> step=%0b dir=%0b pol=%0b pd=%0b busy=%0b",
                     i, vecs[i].en, vecs[i].div, vecs[i].mx, vecs[i].zr,
                     ifc.step_en, ifc.dir, ifc.polarity, ifc.period_done, ifc.busy);
            check($sformatf("vec%0d_step", i), ifc.step_en, vecs[i].step);
            check($sformatf("vec%0d_dir", i), ifc.dir, vecs[i].dir);
            check($sformatf("vec%0d_pol", i), ifc.polarity, vecs[i].pol);
            check($sformatf("vec%0d_pd", i), ifc.period_done, vecs[i].pd);
            check($sformatf("vec%0d_busy", i), ifc.busy, vecs[i].busy);
        end
        tb_max  = 1'b0;
        tb_zero = 1'b0;

        // Asynchronous reset landing in a step_en cycle.
        ifc.div_cfg = 8'd0;
        ifc.en      = 1'b1;
        tick();
        tick();
        tb_max = 1'b1;
        tick();
        tb_max = 1'b0;
        check("arst_pre_dir", ifc.dir, 1);
        check("arst_pre_step", ifc.step_en, 1);
        #2 rst = 1'b0;
        #1;
        $display("async reset: step=%0b dir=%0b pol=%0b pd=%0b busy=%0b",
                 ifc.step_en, ifc.dir, ifc.polarity, ifc.period_done, ifc.busy);
        check("arst_step", ifc.step_en, 0);
        check("arst_dir", ifc.dir, 0);
        check("arst_pol", ifc.polarity, 0);
        check("arst_pd", ifc.period_done, 0);
        check("arst_busy", ifc.busy, 0);
        ifc.en = 1'b0;
        tick();
        check("arst_hold_step", ifc.step_en, 0);
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("arst_after%0d_step", k), ifc.step_en, 0);
            check($sformatf("arst_after%0d_busy", k), ifc.busy, 0);
        end

        // div_cfg=3: first step 4 cycles after entering RUN; en low for six cycles must not disturb pacing.
        ifc.div_cfg = 8'd3;
        ifc.en      = 1'b1;
        tick();
        check("div3_enter_busy", ifc.busy, 1);
        check("div3_enter_step", ifc.step_en, 0);
        for (int k = 1; k <= 40; k++) begin
            if (k == 13) ifc.en = 1'b0;
            if (k == 19) ifc.en = 1'b1;
            tick();
            $display("div3 cycle %0d: en=%0b step=%0b busy=%0b", k, ifc.en, ifc.step_en, ifc.busy);
            check($sformatf("div3_c%0d_step", k), ifc.step_en, (k % 4 == 0) ? 1 : 0);
            check($sformatf("div3_c%0d_busy", k), ifc.busy, 1);
        end

        // Behavioural datapath, div_cfg=0: 127 steps up, 127 down per lobe, 508 per period.
        rst         = 1'b0;
        ifc.en      = 1'b0;
        ifc.div_cfg = 8'd0;
        model_mode  = 1'b1;
        tick();
        @(negedge clk) rst = 1'b1;
        ifc.en = 1'b1;
        wait_pd(2000, cyc);
        $display("model: first period_done after %0d cycles", cyc);
        check("model_pd1", ifc.period_done, 1);
        check("model_pd1_cnt", dp_cnt, 0);
        check("model_pd1_pol", ifc.polarity, 0);
        for (int k = 1; k <= 509; k++) begin
            tick();
            if (k == 126) check("model_k126_dir", ifc.dir, 0);
            if (k == 127) begin
                check("model_k127_dir", ifc.dir, 1);
                check("model_k127_cnt", dp_cnt, 127);
                check("model_k127_pol", ifc.polarity, 0);
            end
            if (k == 253) check("model_k253_pol", ifc.polarity, 0);
            if (k == 254) begin
                check("model_k254_pol", ifc.polarity, 1);
                check("model_k254_dir", ifc.dir, 0);
                check("model_k254_cnt", dp_cnt, 0);
                check("model_k254_pd", ifc.period_done, 0);
            end
            if (k == 381) check("model_k381_dir", ifc.dir, 1);
            if (k == 300) ifc.en = 1'b0;
            if (k == 400) check("model_k400_busy", ifc.busy, 1);
            if (k == 507) begin
                check("model_k507_busy", ifc.busy, 1);
                check("model_k507_pd", ifc.period_done, 0);
            end
            if (k == 508) begin
                $display("model: stop at step %0d pd=%0b busy=%0b pol=%0b", k,
                         ifc.period_done, ifc.busy, ifc.polarity);
                check("model_k508_pd", ifc.period_done, 1);
                check("model_k508_busy", ifc.busy, 0);
                check("model_k508_pol", ifc.polarity, 0);
                check("model_k508_step", ifc.step_en, 0);
            end
            if (k == 509) begin
                check("model_k509_step", ifc.step_en, 0);
                check("model_k509_busy", ifc.busy, 0);
                check("model_k509_pd", ifc.period_done, 0);
            end
        end

`ifdef SINE_CTRL_BURST_EN
        // burst_cfg=2 with en held high: two periods, then parked until en toggles.
        rst           = 1'b0;
        ifc.en        = 1'b0;
        ifc.burst_cfg = 8'd2;
        tick();
        @(negedge clk) rst = 1'b1;
        ifc.en = 1'b1;
        wait_pd(2000, cyc);
        check("burst_pd1", ifc.period_done, 1);
        check("burst_pd1_busy", ifc.busy, 1);
        tick();
        wait_pd(2000, cyc);
        $display("burst: second period_done after %0d cycles, busy=%0b", cyc, ifc.busy);
        check("burst_pd2", ifc.period_done, 1);
        check("burst_pd2_cycles", cyc, 507);
        check("burst_pd2_busy", ifc.busy, 0);
        pd_seen = 0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (ifc.period_done === 1'b1 || ifc.busy === 1'b1) pd_seen++;
        end
        check("burst_parked", pd_seen, 0);
        ifc.en = 1'b0;
        tick();
        check("burst_en_low_busy", ifc.busy, 0);
        ifc.en = 1'b1;
        tick();
        check("burst_rearm_busy", ifc.busy, 1);
        ifc.burst_cfg = 8'd0;
`else
        pd_seen = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
